// File: rtl/core_ex_dmem_resp.sv
// core_ex_dmem_resp: single-outstanding data-memory responder for the EX-stage LSU.
// Ports: clk_i/rst_i (sync, active-high); req_* valid/ready request (write, byte addr, data, byte mask);
//        rsp_* valid/ready response (rdata, err); busy_o high whenever a transaction is in flight.
// Latency: rsp_valid_o rises LATENCY cycles after acceptance; req_ready_o is low until the response handshakes.
module core_ex_dmem_resp #(
  parameter int XLEN       = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [XLEN/8-1:0] req_wmask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int NB    = XLEN / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  write_q, err_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [XLEN-1:0]       rsp_rdata_q;
  logic                  rsp_err_q;
  logic [XLEN-1:0]       mem_q [DEPTH];

  logic                  accept, enter_resp;
  logic [DEPTH_LOG2-1:0] req_idx, rd_idx;
  logic                  req_err, rd_write, rd_err;

  // Byte offset inside the word is the initiator's concern (it selects lanes via wmask).
  logic [2:0] unused_addr_lsb;
  assign unused_addr_lsb = req_addr_i[2:0];

  assign req_idx = req_addr_i[DEPTH_LOG2+2:3];
  assign req_err = |req_addr_i[XLEN-1:DEPTH_LOG2+3];

  // With LATENCY=1 RESP is entered on the acceptance edge itself, before the
  // capture registers hold the request, so the read side looks at the live request.
  assign rd_idx   = (state_q == S_IDLE) ? req_idx     : idx_q;
  assign rd_write = (state_q == S_IDLE) ? req_write_i : write_q;
  assign rd_err   = (state_q == S_IDLE) ? req_err     : err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    enter_resp  = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = ~rst_i;
        if (req_valid_i && !rst_i) begin
          accept = 1'b1;
          cnt_d  = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Leave as the counter steps to zero, so WAIT lasts LATENCY-1 cycles
        // and RESP is visible LATENCY cycles after acceptance.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stores commit on the acceptance edge; array contents are never reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_write_i && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (req_wmask_i[b]) mem_q[req_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write_i;
        err_q   <= req_err;
        idx_q   <= req_idx;
      end
      if (enter_resp) begin
        rsp_err_q   <= rd_err;
        rsp_rdata_q <= (rd_write || rd_err) ? '0 : mem_q[rd_idx];
      end else if (state_q == S_RESP && rsp_ready_i) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= '0;
      end
    end
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
